// File: rtl/drive_input_arbiter_if.sv
// drive_input_arbiter_if
//   Bundles the per-source drive requests and the merged drive command.
//   master: input decoders side (drives src_*, freeze; observes the command)
//   slave : arbiter side (observes src_*, freeze; drives the command)
//   src_accel  [2*NUM_SRC] per source {fwd,back}, src i at [2i+1:2i]
//   src_turn   [2*NUM_SRC] per source 00 left, 01 right, 11 straight
//   src_active [NUM_SRC]   source present/enabled
//   freeze                 hold all arbiter state
//   forward, backward, turn, sel_src, owner_valid, cmd_change  merged command
interface drive_input_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1
);
  logic [2*NUM_SRC-1:0] src_accel;
  logic [2*NUM_SRC-1:0] src_turn;
  logic [NUM_SRC-1:0]   src_active;
  logic                 freeze;
  logic                 forward;
  logic                 backward;
  logic [1:0]           turn;
  logic [SEL_W-1:0]     sel_src;
  logic                 owner_valid;
  logic                 cmd_change;

  modport master (
    output src_accel, src_turn, src_active, freeze,
    input  forward, backward, turn, sel_src, owner_valid, cmd_change
  );

  modport slave (
    input  src_accel, src_turn, src_active, freeze,
    output forward, backward, turn, sel_src, owner_valid, cmd_change
  );
endinterface

// File: rtl/drive_input_arbiter.sv
// drive_input_arbiter
//   Merges NUM_SRC drive-control sources into one debounced, registered
//   {forward, backward, turn} command with sticky ownership, optional
//   priority preemption (PREEMPT) and an idle timeout on a neutral owner.
//   Source 0 has the highest priority.
// Ports
//   clock   system clock
//   resetn  synchronous, active-low reset
//   bus     drive_input_arbiter_if.slave (src_* and freeze in, command out)
// Build option
//   DRIVE_ARB_SYNC_EN: route every src_* bit through a 2-flop synchroniser
//   (for GPIO-driven sources); otherwise the inputs feed sanitising directly.
//
// state | meaning
// IDLE  | no owner, command is stop/straight, waiting for a requesting source
// OWN   | sel_src owns the command; timeout counts neutral owner cycles
module drive_input_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int SEL_W          = 1,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_W          = 25,
  parameter int PREEMPT        = 1
) (
  input logic                  clock,
  input logic                  resetn,
  drive_input_arbiter_if.slave bus
);

  localparam int         DB_W    = $clog2(STABLE_CYCLES + 1);
  // {accel[1:0], turn[1:0]} of stop / straight
  localparam logic [3:0] NEUTRAL = 4'b0011;

  typedef enum logic {IDLE, OWN} state_e;

  logic [2*NUM_SRC-1:0] accel_s, turn_s;
  logic [NUM_SRC-1:0]   active_s;

`ifdef DRIVE_ARB_SYNC_EN
  logic [2*NUM_SRC-1:0] accel_m_q, accel_s_q, turn_m_q, turn_s_q;
  logic [NUM_SRC-1:0]   active_m_q, active_s_q;

  // Synchronisers ignore freeze so the view of the pins stays current.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      accel_m_q  <= '0;
      accel_s_q  <= '0;
      turn_m_q   <= '1;
      turn_s_q   <= '1;
      active_m_q <= '0;
      active_s_q <= '0;
    end else begin
      accel_m_q  <= bus.src_accel;
      accel_s_q  <= accel_m_q;
      turn_m_q   <= bus.src_turn;
      turn_s_q   <= turn_m_q;
      active_m_q <= bus.src_active;
      active_s_q <= active_m_q;
    end
  end

  assign accel_s  = accel_s_q;
  assign turn_s   = turn_s_q;
  assign active_s = active_s_q;
`else
  assign accel_s  = bus.src_accel;
  assign turn_s   = bus.src_turn;
  assign active_s = bus.src_active;
`endif

  logic [3:0]      san_v    [NUM_SRC];
  logic [3:0]      cand_q   [NUM_SRC];
  logic [3:0]      cand_d   [NUM_SRC];
  logic [3:0]      acc_q    [NUM_SRC];
  logic [3:0]      acc_d    [NUM_SRC];
  logic [DB_W-1:0] db_cnt_q [NUM_SRC];
  logic [DB_W-1:0] db_cnt_d [NUM_SRC];

  // Accepted value is written on the same edge the count reaches
  // STABLE_CYCLES, so only the output register follows acceptance.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      san_v[i][3:2] = (accel_s[2*i +: 2] == 2'b11) ? 2'b00 : accel_s[2*i +: 2];
      san_v[i][1:0] = (turn_s[2*i +: 2] == 2'b10) ? 2'b11 : turn_s[2*i +: 2];
      cand_d[i]     = cand_q[i];
      db_cnt_d[i]   = db_cnt_q[i];
      acc_d[i]      = acc_q[i];
      if (!bus.freeze) begin
        if (san_v[i] == cand_q[i]) begin
          if (db_cnt_q[i] != DB_W'(STABLE_CYCLES)) db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end else begin
          cand_d[i]   = san_v[i];
          db_cnt_d[i] = DB_W'(1);
        end
        if (db_cnt_d[i] == DB_W'(STABLE_CYCLES)) acc_d[i] = cand_d[i];
      end
    end
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [3:0]       out_q, out_d;
  logic             cmd_q, cmd_d;

  logic             req_any;
  logic [SEL_W-1:0] req_idx;
  logic [3:0]       req_val, own_val;
  logic             own_act;

  // Lowest-index requesting source, plus muxed views of owner and winner.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_s[i] && (acc_q[i] != NEUTRAL)) begin
        req_any = 1'b1;
        req_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    own_val = NEUTRAL;
    own_act = 1'b0;
    req_val = NEUTRAL;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == sel_q) begin
        own_val = acc_q[i];
        own_act = active_s[i];
      end
      if (SEL_W'(i) == req_idx) req_val = acc_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    out_d   = out_q;
    cmd_d   = 1'b0;
    if (!bus.freeze) begin
      case (state_q)
        IDLE: begin
          tmo_d = '0;
          out_d = NEUTRAL;
          if (req_any) begin
            state_d = OWN;
            sel_d   = req_idx;
            out_d   = req_val;
          end
        end
        OWN: begin
          // Release wins over preemption; re-acquisition happens from IDLE.
          if (!own_act || (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state_d = IDLE;
            tmo_d   = '0;
            out_d   = NEUTRAL;
          end else if ((PREEMPT != 0) && req_any && (req_idx < sel_q)) begin
            sel_d = req_idx;
            tmo_d = '0;
            out_d = req_val;
          end else begin
            tmo_d = (own_val == NEUTRAL) ? tmo_q + CNT_W'(1) : '0;
            out_d = own_val;
          end
        end
        default: state_d = IDLE;
      endcase
      cmd_d = ({out_d, sel_d} != {out_q, sel_q});
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cand_q[i]   <= NEUTRAL;
        acc_q[i]    <= NEUTRAL;
        db_cnt_q[i] <= '0;
      end
      state_q <= IDLE;
      sel_q   <= '0;
      tmo_q   <= '0;
      out_q   <= NEUTRAL;
      cmd_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cand_q[i]   <= cand_d[i];
        acc_q[i]    <= acc_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q <= state_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      out_q   <= out_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.forward     = out_q[3];
  assign bus.backward    = out_q[2];
  assign bus.turn        = out_q[1:0];
  assign bus.sel_src     = sel_q;
  assign bus.owner_valid = (state_q == OWN);
  assign bus.cmd_change  = cmd_q;

endmodule

// File: tb/tb_drive_input_arbiter.sv
// tb_drive_input_arbiter
//   Directed stimulus for drive_input_arbiter (2 sources, STABLE_CYCLES=4,
//   TIMEOUT_CYCLES=16, PREEMPT=1). A reference model updated every rising
//   edge predicts the command; every falling edge compares the DUT to it.
//   Literal expectations pin latency, preemption, timeout and freeze.
//   Latencies follow DRIVE_ARB_SYNC_EN when it is defined for the build.
module tb_drive_input_arbiter;
  localparam int NS     = 2;
  localparam int STABLE = 4;
  localparam int TMO    = 16;
`ifdef DRIVE_ARB_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int         LAT     = SYNC_D + STABLE + 1;
  localparam logic [3:0] NEUTRAL = 4'b0011;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  drive_input_arbiter_if #(.NUM_SRC(NS), .SEL_W(1)) bus ();

  drive_input_arbiter #(
    .NUM_SRC(NS), .SEL_W(1), .STABLE_CYCLES(STABLE),
    .TIMEOUT_CYCLES(TMO), .CNT_W(5), .PREEMPT(1)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] san(input logic [1:0] a, input logic [1:0] t);
    san = {(a == 2'b11) ? 2'b00 : a, (t == 2'b10) ? 2'b11 : t};
  endfunction

  // Reference model: pin pipeline, sliding debounce window, ownership rules.
  logic [3:0]    p0_v [NS];
  logic [3:0]    p1_v [NS];
  logic [NS-1:0] p0_a, p1_a;
  logic [3:0]    win  [NS][$];
  logic [3:0]    m_acc[NS];
  bit            m_own;
  int            m_tmo, m_sel;
  logic [3:0]    m_out;
  bit            m_cmd;

  always @(posedge clock) begin
    logic [3:0]    raw[NS];
    logic [3:0]    sv [NS];
    logic [NS-1:0] sa;
    logic [3:0]    new_out;
    int            new_sel, req_lo;
    bit            same;
    for (int i = 0; i < NS; i++) raw[i] = san(bus.src_accel[2*i +: 2], bus.src_turn[2*i +: 2]);
    if (!resetn) begin
      for (int i = 0; i < NS; i++) begin
        p0_v[i] = NEUTRAL;
        p1_v[i] = NEUTRAL;
        win[i].delete();
        m_acc[i] = NEUTRAL;
      end
      p0_a = '0; p1_a = '0;
      m_own = 1'b0; m_tmo = 0; m_sel = 0; m_out = NEUTRAL; m_cmd = 1'b0;
    end else begin
      if (SYNC_D == 2) begin
        sv = p1_v; sa = p1_a;
        p1_v = p0_v; p1_a = p0_a;
        p0_v = raw; p0_a = bus.src_active;
      end else begin
        sv = raw; sa = bus.src_active;
      end
      if (bus.freeze) begin
        m_cmd = 1'b0;
      end else begin
        req_lo = -1;
        for (int i = NS - 1; i >= 0; i--) if (sa[i] && m_acc[i] != NEUTRAL) req_lo = i;
        new_sel = m_sel;
        if (!m_own) begin
          m_tmo = 0;
          new_out = NEUTRAL;
          if (req_lo >= 0) begin
            m_own = 1'b1; new_sel = req_lo; new_out = m_acc[req_lo];
          end
        end else if (!sa[m_sel] || m_tmo == TMO - 1) begin
          m_own = 1'b0; m_tmo = 0; new_out = NEUTRAL;
        end else begin
          if (req_lo >= 0 && req_lo < m_sel) begin
            new_sel = req_lo; m_tmo = 0;
          end else if (m_acc[m_sel] == NEUTRAL) m_tmo++;
          else m_tmo = 0;
          new_out = m_acc[new_sel];
        end
        m_cmd = (new_out != m_out) || (new_sel != m_sel);
        m_out = new_out;
        m_sel = new_sel;
        // accepted = newest value once the last STABLE samples all agree
        for (int i = 0; i < NS; i++) begin
          win[i].push_back(sv[i]);
          if (win[i].size() > STABLE) void'(win[i].pop_front());
          if (win[i].size() == STABLE) begin
            same = 1'b1;
            for (int j = 0; j < STABLE; j++) if (win[i][j] != win[i][0]) same = 1'b0;
            if (same) m_acc[i] = win[i][0];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_forward",  int'(bus.forward),     int'(m_out[3]));
      chk("model_backward", int'(bus.backward),    int'(m_out[2]));
      chk("model_turn",     int'(bus.turn),        int'(m_out[1:0]));
      chk("model_sel_src",  int'(bus.sel_src),     m_sel);
      chk("model_owner",    int'(bus.owner_valid), int'(m_own));
      chk("model_cmd",      int'(bus.cmd_change),  int'(m_cmd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] t, input logic [1:0] act);
    bus.src_accel  = a;
    bus.src_turn   = t;
    bus.src_active = act;
  endtask

  initial begin
    bus.freeze = 1'b0;
    drive(4'b0000, 4'b1111, 2'b00);
    resetn = 1'b0;
    // 1: reset with toggling inputs
    @(negedge clock);
    chk_en = 1'b1;
    drive(4'b1010, 4'b1111, 2'b11);
    cyc(1);
    drive(4'b0101, 4'b0000, 2'b11);
    cyc(1);
    chk("rst_forward",  bus.forward, 0);
    chk("rst_backward", bus.backward, 0);
    chk("rst_turn",     bus.turn, 3);
    chk("rst_owner",    bus.owner_valid, 0);
    chk("rst_cmd",      bus.cmd_change, 0);
    resetn = 1'b1;
    drive(4'b0000, 4'b1111, 2'b00);
    cyc(10);

    // 2: src1 forward acquires ownership after LAT cycles
    drive(4'b1000, 4'b1111, 2'b11);
    cyc(LAT - 1);
    chk("s2_not_yet", bus.owner_valid, 0);
    cyc(1);
    chk("s2_forward", bus.forward, 1);
    chk("s2_sel",     bus.sel_src, 1);
    chk("s2_owner",   bus.owner_valid, 1);
    chk("s2_cmd",     bus.cmd_change, 1);
    cyc(1);
    chk("s2_cmd_pulse", bus.cmd_change, 0);

    // 3: 3-cycle glitch on src0 is filtered
    drive(4'b1010, 4'b1111, 2'b11);
    cyc(3);
    drive(4'b1000, 4'b1111, 2'b11);
    cyc(10);
    chk("s3_sel",     bus.sel_src, 1);
    chk("s3_forward", bus.forward, 1);

    // 4: src0 turn-left preempts src1
    drive(4'b1000, 4'b1100, 2'b11);
    cyc(LAT - 1);
    chk("s4_still_src1", bus.sel_src, 1);
    cyc(1);
    chk("s4_sel",     bus.sel_src, 0);
    chk("s4_turn",    bus.turn, 0);
    chk("s4_forward", bus.forward, 0);

    // 5a: owner goes neutral -> release on 16th neutral cycle, src1 re-acquires
    drive(4'b1000, 4'b1111, 2'b11);
    cyc(SYNC_D + STABLE + 15);
    chk("s5_hold_15", bus.owner_valid, 1);
    cyc(1);
    chk("s5_release", bus.owner_valid, 0);
    cyc(1);
    chk("s5_reacq_owner", bus.owner_valid, 1);
    chk("s5_reacq_sel",   bus.sel_src, 1);

    // 5b: owner src_active falls
    drive(4'b1000, 4'b1111, 2'b01);
    cyc(SYNC_D);
    chk("s5b_hold", bus.owner_valid, 1);
    cyc(1);
    chk("s5b_release", bus.owner_valid, 0);

    // 6: illegal codes on src0 are neutral
    drive(4'b1011, 4'b1110, 2'b01);
    cyc(12);
    chk("s6_no_owner", bus.owner_valid, 0);

    // freeze during acquisition
    drive(4'b0000, 4'b1111, 2'b00);
    cyc(10);
    bus.freeze = 1'b1;
    drive(4'b1000, 4'b1111, 2'b11);
    cyc(12);
    chk("frz_held_idle", bus.owner_valid, 0);
    bus.freeze = 1'b0;
    cyc(STABLE);
    chk("frz_not_yet", bus.owner_valid, 0);
    cyc(1);
    chk("frz_forward", bus.forward, 1);
    chk("frz_sel",     bus.sel_src, 1);
    chk("frz_cmd",     bus.cmd_change, 1);

    // freeze while owning: a new owner value must not pass through
    bus.freeze = 1'b1;
    drive(4'b0100, 4'b1111, 2'b11);
    cyc(10);
    chk("frz_hold_fwd",  bus.forward, 1);
    chk("frz_hold_back", bus.backward, 0);
    bus.freeze = 1'b0;
    cyc(STABLE);
    chk("frz_hold_fwd2", bus.forward, 1);
    cyc(1);
    chk("unfrz_back", bus.backward, 1);
    chk("unfrz_fwd",  bus.forward, 0);
    chk("unfrz_cmd",  bus.cmd_change, 1);

    // reset mid-operation discards pending candidates
    drive(4'b0101, 4'b1111, 2'b11);
    cyc(3);
    resetn = 1'b0;
    cyc(1);
    chk("mrst_owner", bus.owner_valid, 0);
    chk("mrst_turn",  bus.turn, 3);
    resetn = 1'b1;
    cyc(LAT - 1);
    chk("mrst_not_yet", bus.owner_valid, 0);
    cyc(1);
    chk("mrst_sel",  bus.sel_src, 0);
    chk("mrst_back", bus.backward, 1);
    chk("mrst_own",  bus.owner_valid, 1);
    cyc(5);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
